// File: rtl/calc_pkg.sv
// calc_pkg: shared types and constants for the calculator sequencer.
// Op codes match the keyboard interface encoding.
package calc_pkg;

  localparam int BCD_W = 4;

  localparam logic [1:0] OP_NONE = 2'd0;
  localparam logic [1:0] OP_ADD  = 2'd1;
  localparam logic [1:0] OP_SUB  = 2'd2;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ENT_A,
    ST_OPER,
    ST_ENT_B,
    ST_CMP,
    ST_CALC,
    ST_SHOW
  } state_e;

endpackage

// File: rtl/calc_ctrl_if.sv
// calc_ctrl_if: classified key events in, display value out.
// master = keyboard/display side, slave = calc_ctrl.
interface calc_ctrl_if #(
  parameter int DIGITS = 3
);
  logic                  btn_press;
  logic                  is_number;
  logic                  is_op;
  logic                  is_eq;
  logic [3:0]            num_val;
  logic [1:0]            op_val;
  logic [4*DIGITS-1:0]   disp_bcd;
  logic                  disp_neg;
  logic                  disp_ovf;
  logic [1:0]            op_pending;
  logic                  busy;

  modport master (
    output btn_press, is_number, is_op, is_eq, num_val, op_val,
    input  disp_bcd, disp_neg, disp_ovf, op_pending, busy
  );

  modport slave (
    input  btn_press, is_number, is_op, is_eq, num_val, op_val,
    output disp_bcd, disp_neg, disp_ovf, op_pending, busy
  );
endinterface

// File: rtl/bcd_digit_addsub.sv
// bcd_digit_addsub: one BCD digit add (sub_i=0) or subtract (sub_i=1)
// with carry/borrow in and out. Purely combinational.
module bcd_digit_addsub
  import calc_pkg::*;
(
  input  logic [BCD_W-1:0] a_i,
  input  logic [BCD_W-1:0] b_i,
  input  logic             cin_i,
  input  logic             sub_i,
  output logic [BCD_W-1:0] d_o,
  output logic             cout_o
);

  logic [BCD_W:0] sum;
  logic [BCD_W:0] diff;

  // Binary add/subtract then decimal-correct the digit.
  always_comb begin
    sum    = 5'(a_i) + 5'(b_i) + 5'(cin_i);
    diff   = 5'(a_i) - 5'(b_i) - 5'(cin_i);
    d_o    = '0;
    cout_o = 1'b0;
    if (sub_i) begin
      if (diff[BCD_W]) begin
        d_o    = 4'(diff + 5'd10);
        cout_o = 1'b1;
      end else begin
        d_o = diff[BCD_W-1:0];
      end
    end else if (sum > 5'd9) begin
      d_o    = 4'(sum + 5'd6);
      cout_o = 1'b1;
    end else begin
      d_o = sum[BCD_W-1:0];
    end
  end

endmodule

// File: rtl/calc_ctrl.sv
// calc_ctrl: calculator sequencer. Builds two BCD operands from key events,
// runs a digit-serial add/subtract and drives the display.
// Optional feature macro CALC_CHAIN_EN: an operator in SHOW continues
// from the previous result (signed) instead of being ignored.
module calc_ctrl
  import calc_pkg::*;
#(
  parameter int DIGITS = 3
) (
  input  logic        clk,
  input  logic        reset,
  calc_ctrl_if.slave  bus
);

  localparam int              W       = BCD_W * DIGITS;
  localparam int              CNT_W   = 4;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DIGITS);

  state_e           state_q, state_d;
  logic             prev_q;
  logic [W-1:0]     a_q, a_d;
  logic             a_neg_q, a_neg_d;
  logic [W-1:0]     b_q, b_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       op_q, op_d;
  logic [W-1:0]     x_q, x_d;
  logic [W-1:0]     y_q, y_d;
  logic             sub_q, sub_d;
  logic [W-1:0]     res_q, res_d;
  logic             res_neg_q, res_neg_d;
  logic             carry_q, carry_d;
  logic [CNT_W-1:0] idx_q, idx_d;
  logic [W-1:0]     disp_q, disp_d;
  logic             neg_q, neg_d;
  logic             ovf_q, ovf_d;

  logic             evt, dig_ev, op_ev, eq_ev;
  logic [W-1:0]     dig_w;
  logic             eff_sub, a_lt_b;
  logic [BCD_W-1:0] dsum;
  logic             dcout;

  bcd_digit_addsub u_digit (
    .a_i    (x_q[BCD_W-1:0]),
    .b_i    (y_q[BCD_W-1:0]),
    .cin_i  (carry_q),
    .sub_i  (sub_q),
    .d_o    (dsum),
    .cout_o (dcout)
  );

  // State and datapath registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= ST_IDLE;
      prev_q    <= 1'b0;
      a_q       <= '0;
      a_neg_q   <= 1'b0;
      b_q       <= '0;
      cnt_q     <= '0;
      op_q      <= OP_NONE;
      x_q       <= '0;
      y_q       <= '0;
      sub_q     <= 1'b0;
      res_q     <= '0;
      res_neg_q <= 1'b0;
      carry_q   <= 1'b0;
      idx_q     <= '0;
      disp_q    <= '0;
      neg_q     <= 1'b0;
      ovf_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      prev_q    <= bus.btn_press;
      a_q       <= a_d;
      a_neg_q   <= a_neg_d;
      b_q       <= b_d;
      cnt_q     <= cnt_d;
      op_q      <= op_d;
      x_q       <= x_d;
      y_q       <= y_d;
      sub_q     <= sub_d;
      res_q     <= res_d;
      res_neg_q <= res_neg_d;
      carry_q   <= carry_d;
      idx_q     <= idx_d;
      disp_q    <= disp_d;
      neg_q     <= neg_d;
      ovf_q     <= ovf_d;
    end
  end

  // Next-state, operand entry, compare and digit-serial sequencing.
  always_comb begin
    state_d   = state_q;
    a_d       = a_q;
    a_neg_d   = a_neg_q;
    b_d       = b_q;
    cnt_d     = cnt_q;
    op_d      = op_q;
    x_d       = x_q;
    y_d       = y_q;
    sub_d     = sub_q;
    res_d     = res_q;
    res_neg_d = res_neg_q;
    carry_d   = carry_q;
    idx_d     = idx_q;
    neg_d     = neg_q;
    ovf_d     = ovf_q;
    disp_d    = disp_q;

    evt    = bus.btn_press & ~prev_q;
    dig_ev = evt & bus.is_number;
    op_ev  = evt & ~bus.is_number & bus.is_op &
             ((bus.op_val == OP_ADD) || (bus.op_val == OP_SUB));
    eq_ev  = evt & ~bus.is_number & ~bus.is_op & bus.is_eq;
    dig_w  = W'(bus.num_val);

`ifdef CALC_CHAIN_EN
    eff_sub = (op_q == OP_SUB) ^ a_neg_q;
`else
    eff_sub = (op_q == OP_SUB);
`endif
    a_lt_b  = (a_q < b_q);

    unique case (state_q)
      ST_IDLE, ST_SHOW: begin
        if (dig_ev) begin
          a_d     = dig_w;
          a_neg_d = 1'b0;
          cnt_d   = CNT_W'(1);
          op_d    = OP_NONE;
          neg_d   = 1'b0;
          ovf_d   = 1'b0;
          state_d = ST_ENT_A;
        end else if (op_ev && state_q == ST_IDLE) begin
          a_d     = '0;
          a_neg_d = 1'b0;
          op_d    = bus.op_val;
          state_d = ST_OPER;
        end
`ifdef CALC_CHAIN_EN
        else if (op_ev) begin
          a_d     = res_q;
          a_neg_d = res_neg_q;
          cnt_d   = CNT_MAX;
          op_d    = bus.op_val;
          ovf_d   = 1'b0;
          state_d = ST_OPER;
        end
`endif
      end
      ST_ENT_A: begin
        if (dig_ev) begin
          if (cnt_q < CNT_MAX) begin
            a_d   = (a_q << BCD_W) | dig_w;
            cnt_d = cnt_q + CNT_W'(1);
          end
        end else if (op_ev) begin
          op_d    = bus.op_val;
          state_d = ST_OPER;
        end else if (eq_ev) begin
          res_d     = a_q;
          res_neg_d = a_neg_q;
          neg_d     = a_neg_q;
          ovf_d     = 1'b0;
          state_d   = ST_SHOW;
        end
      end
      ST_OPER: begin
        if (dig_ev) begin
          b_d     = dig_w;
          cnt_d   = CNT_W'(1);
          state_d = ST_ENT_B;
        end else if (op_ev) begin
          op_d = bus.op_val;
        end else if (eq_ev) begin
          b_d     = '0;
          state_d = ST_CMP;
        end
      end
      ST_ENT_B: begin
        if (dig_ev) begin
          if (cnt_q < CNT_MAX) begin
            b_d   = (b_q << BCD_W) | dig_w;
            cnt_d = cnt_q + CNT_W'(1);
          end
        end else if (eq_ev) begin
          state_d = ST_CMP;
        end
      end
      ST_CMP: begin
        // Subtraction runs larger-minus-smaller; the sign flips when |A|<|B|.
        if (eff_sub && a_lt_b) begin
          x_d = b_q;
          y_d = a_q;
        end else begin
          x_d = a_q;
          y_d = b_q;
        end
        sub_d     = eff_sub;
        res_neg_d = eff_sub ? (a_neg_q ^ a_lt_b) : a_neg_q;
        carry_d   = 1'b0;
        idx_d     = '0;
        state_d   = ST_CALC;
      end
      ST_CALC: begin
        // Result digits shift in from the top so the LSD lands at bit 0
        // after the last cycle.
        x_d     = x_q >> BCD_W;
        y_d     = y_q >> BCD_W;
        res_d   = (res_q >> BCD_W) | (W'(dsum) << (W - BCD_W));
        carry_d = dcout;
        idx_d   = idx_q + CNT_W'(1);
        if (idx_q == CNT_MAX - CNT_W'(1)) begin
          if (res_d == '0) begin
            res_neg_d = 1'b0;
          end
          neg_d   = res_neg_d;
          ovf_d   = dcout & ~sub_q;
          state_d = ST_SHOW;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    unique case (state_d)
      ST_IDLE:            disp_d = '0;
      ST_ENT_A, ST_OPER:  disp_d = a_d;
      ST_ENT_B:           disp_d = b_d;
      ST_SHOW:            disp_d = res_d;
      default:            disp_d = disp_q;
    endcase
  end

  assign bus.disp_bcd   = disp_q;
  assign bus.disp_neg   = neg_q;
  assign bus.disp_ovf   = ovf_q;
  assign bus.op_pending = op_q;
  assign bus.busy       = (state_q == ST_CMP) || (state_q == ST_CALC);

endmodule

// File: tb/tb_calc_ctrl.sv
// tb_calc_ctrl: directed tests for calc_ctrl with DIGITS=3.
module tb_calc_ctrl;
  import calc_pkg::*;

  localparam int DIGITS = 3;

  logic clk = 1'b0;
  logic reset = 1'b0;
  int   checks = 0;
  int   failures = 0;

  calc_ctrl_if #(.DIGITS(DIGITS)) bus ();

  calc_ctrl #(.DIGITS(DIGITS)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic release_keys();
    bus.btn_press = 1'b0;
    bus.is_number = 1'b0;
    bus.is_op     = 1'b0;
    bus.is_eq     = 1'b0;
    bus.num_val   = 4'd0;
    bus.op_val    = 2'd0;
  endtask

  // kind: 0 digit, 1 operator, 2 equals
  task automatic press(input int kind, input logic [3:0] v);
    @(negedge clk);
    bus.btn_press = 1'b1;
    bus.is_number = (kind == 0);
    bus.is_op     = (kind == 1);
    bus.is_eq     = (kind == 2);
    if (kind == 0) bus.num_val = v;
    if (kind == 1) bus.op_val = v[1:0];
    @(negedge clk);
    release_keys();
    @(negedge clk);
  endtask

  task automatic wait_done();
    int n = 0;
    while (bus.busy && n < 50) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (bus.busy !== 1'b0) begin
      failures++;
      $display("FAIL wait_done busy stuck got=%b exp=0", bus.busy);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0;
    release_keys();
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_reset();
    @(negedge clk);
    reset = 1'b0;
    #1;
    checks++; if (bus.disp_bcd !== 12'h000) begin failures++; $display("FAIL reset disp_bcd got=%h exp=000", bus.disp_bcd); end
    checks++; if (bus.disp_neg !== 1'b0) begin failures++; $display("FAIL reset disp_neg got=%b exp=0", bus.disp_neg); end
    checks++; if (bus.disp_ovf !== 1'b0) begin failures++; $display("FAIL reset disp_ovf got=%b exp=0", bus.disp_ovf); end
    checks++; if (bus.op_pending !== 2'd0) begin failures++; $display("FAIL reset op_pending got=%0d exp=0", bus.op_pending); end
    checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL reset busy got=%b exp=0", bus.busy); end
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_ignored();
    do_reset();
    press(1, 4'd3);
    checks++; if (bus.op_pending !== 2'd0) begin failures++; $display("FAIL ign_op3 op_pending got=%0d exp=0", bus.op_pending); end
    press(2, 4'd0);
    checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL ign_eq busy got=%b exp=0", bus.busy); end
    checks++; if (bus.disp_bcd !== 12'h000) begin failures++; $display("FAIL ign_eq disp_bcd got=%h exp=000", bus.disp_bcd); end
  endtask

  task automatic test_add_timing();
    int busy_cnt = 0;
    int vis = 0;
    logic [11:0] disp_k4 = '0;
    do_reset();
    press(0, 4'd1);
    press(0, 4'd2);
    checks++; if (bus.disp_bcd !== 12'h012) begin failures++; $display("FAIL add_enta disp_bcd got=%h exp=012", bus.disp_bcd); end
    press(1, 4'd1);
    checks++; if (bus.op_pending !== OP_ADD) begin failures++; $display("FAIL add_op op_pending got=%0d exp=1", bus.op_pending); end
    press(0, 4'd5);
    checks++; if (bus.disp_bcd !== 12'h005) begin failures++; $display("FAIL add_entb disp_bcd got=%h exp=005", bus.disp_bcd); end
    @(negedge clk);
    bus.btn_press = 1'b1;
    bus.is_eq     = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      if (k == 1) release_keys();
      if (bus.busy) busy_cnt++;
      else if (vis == 0) vis = k;
      if (k == 4) disp_k4 = bus.disp_bcd;
    end
    checks++; if (busy_cnt != 4) begin failures++; $display("FAIL add_busy_cycles got=%0d exp=4", busy_cnt); end
    checks++; if (vis != 5) begin failures++; $display("FAIL add_latency first_idle_negedge got=%0d exp=5", vis); end
    checks++; if (disp_k4 !== 12'h005) begin failures++; $display("FAIL add_hold disp_bcd got=%h exp=005", disp_k4); end
    checks++; if (bus.disp_bcd !== 12'h017) begin failures++; $display("FAIL add_res disp_bcd got=%h exp=017", bus.disp_bcd); end
    checks++; if (bus.disp_neg !== 1'b0) begin failures++; $display("FAIL add_res disp_neg got=%b exp=0", bus.disp_neg); end
    checks++; if (bus.disp_ovf !== 1'b0) begin failures++; $display("FAIL add_res disp_ovf got=%b exp=0", bus.disp_ovf); end
  endtask

  task automatic test_sub_neg();
    do_reset();
    press(0, 4'd5); press(1, 4'd2); press(0, 4'd1); press(0, 4'd2); press(2, 4'd0);
    wait_done();
    checks++; if (bus.disp_bcd !== 12'h007) begin failures++; $display("FAIL subneg disp_bcd got=%h exp=007", bus.disp_bcd); end
    checks++; if (bus.disp_neg !== 1'b1) begin failures++; $display("FAIL subneg disp_neg got=%b exp=1", bus.disp_neg); end
    checks++; if (bus.disp_ovf !== 1'b0) begin failures++; $display("FAIL subneg disp_ovf got=%b exp=0", bus.disp_ovf); end
  endtask

  task automatic test_overflow();
    do_reset();
    press(0, 4'd9); press(0, 4'd9); press(0, 4'd9); press(1, 4'd1); press(0, 4'd1); press(2, 4'd0);
    wait_done();
    checks++; if (bus.disp_bcd !== 12'h000) begin failures++; $display("FAIL ovf disp_bcd got=%h exp=000", bus.disp_bcd); end
    checks++; if (bus.disp_ovf !== 1'b1) begin failures++; $display("FAIL ovf disp_ovf got=%b exp=1", bus.disp_ovf); end
    press(0, 4'd4);
    checks++; if (bus.disp_bcd !== 12'h004) begin failures++; $display("FAIL ovf_next disp_bcd got=%h exp=004", bus.disp_bcd); end
    checks++; if (bus.disp_ovf !== 1'b0) begin failures++; $display("FAIL ovf_next disp_ovf got=%b exp=0", bus.disp_ovf); end
  endtask

  task automatic test_digit_limit();
    do_reset();
    press(0, 4'd1); press(0, 4'd2); press(0, 4'd3); press(0, 4'd4);
    checks++; if (bus.disp_bcd !== 12'h123) begin failures++; $display("FAIL limit disp_bcd got=%h exp=123", bus.disp_bcd); end
    press(1, 4'd1); press(1, 4'd2);
    checks++; if (bus.op_pending !== OP_SUB) begin failures++; $display("FAIL op_replace op_pending got=%0d exp=2", bus.op_pending); end
    press(0, 4'd6);
    checks++; if (bus.disp_bcd !== 12'h006) begin failures++; $display("FAIL limit_b disp_bcd got=%h exp=006", bus.disp_bcd); end
    press(2, 4'd0);
    wait_done();
    checks++; if (bus.disp_bcd !== 12'h117) begin failures++; $display("FAIL limit_res disp_bcd got=%h exp=117", bus.disp_bcd); end
    checks++; if (bus.disp_neg !== 1'b0) begin failures++; $display("FAIL limit_res disp_neg got=%b exp=0", bus.disp_neg); end
  endtask

  task automatic test_zero();
    do_reset();
    press(0, 4'd5); press(1, 4'd2); press(0, 4'd5); press(2, 4'd0);
    wait_done();
    checks++; if (bus.disp_bcd !== 12'h000) begin failures++; $display("FAIL zero disp_bcd got=%h exp=000", bus.disp_bcd); end
    checks++; if (bus.disp_neg !== 1'b0) begin failures++; $display("FAIL zero disp_neg got=%b exp=0", bus.disp_neg); end
  endtask

  task automatic test_held_key();
    do_reset();
    @(negedge clk);
    bus.btn_press = 1'b1;
    bus.is_number = 1'b1;
    bus.num_val   = 4'd7;
    repeat (50) @(negedge clk);
    release_keys();
    @(negedge clk);
    checks++; if (bus.disp_bcd !== 12'h007) begin failures++; $display("FAIL held disp_bcd got=%h exp=007", bus.disp_bcd); end
  endtask

  task automatic test_reset_mid_calc();
    do_reset();
    press(0, 4'd1); press(1, 4'd1); press(0, 4'd2);
    @(negedge clk);
    bus.btn_press = 1'b1;
    bus.is_eq     = 1'b1;
    @(negedge clk);
    release_keys();
    @(negedge clk);
    checks++; if (bus.busy !== 1'b1) begin failures++; $display("FAIL midcalc pre busy got=%b exp=1", bus.busy); end
    #2 reset = 1'b0;
    #1;
    checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL midcalc busy got=%b exp=0", bus.busy); end
    checks++; if (bus.disp_bcd !== 12'h000) begin failures++; $display("FAIL midcalc disp_bcd got=%h exp=000", bus.disp_bcd); end
    checks++; if (bus.op_pending !== 2'd0) begin failures++; $display("FAIL midcalc op_pending got=%0d exp=0", bus.op_pending); end
    @(negedge clk);
    reset = 1'b1;
    repeat (5) @(negedge clk);
    checks++; if (bus.disp_bcd !== 12'h000) begin failures++; $display("FAIL midcalc after disp_bcd got=%h exp=000", bus.disp_bcd); end
    checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL midcalc after busy got=%b exp=0", bus.busy); end
  endtask

  task automatic test_chain();
    do_reset();
    press(0, 4'd7); press(1, 4'd2); press(0, 4'd9); press(2, 4'd0);
    wait_done();
    checks++; if (bus.disp_bcd !== 12'h002) begin failures++; $display("FAIL chain1 disp_bcd got=%h exp=002", bus.disp_bcd); end
    checks++; if (bus.disp_neg !== 1'b1) begin failures++; $display("FAIL chain1 disp_neg got=%b exp=1", bus.disp_neg); end
    press(1, 4'd1);
`ifdef CALC_CHAIN_EN
    checks++; if (bus.op_pending !== OP_ADD) begin failures++; $display("FAIL chain_op op_pending got=%0d exp=1", bus.op_pending); end
    press(0, 4'd5); press(2, 4'd0);
    wait_done();
    checks++; if (bus.disp_bcd !== 12'h003) begin failures++; $display("FAIL chain2 disp_bcd got=%h exp=003", bus.disp_bcd); end
    checks++; if (bus.disp_neg !== 1'b0) begin failures++; $display("FAIL chain2 disp_neg got=%b exp=0", bus.disp_neg); end
`else
    checks++; if (bus.disp_bcd !== 12'h002) begin failures++; $display("FAIL nochain disp_bcd got=%h exp=002", bus.disp_bcd); end
    checks++; if (bus.disp_neg !== 1'b1) begin failures++; $display("FAIL nochain disp_neg got=%b exp=1", bus.disp_neg); end
`endif
  endtask

  initial begin
    release_keys();
    reset = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    test_reset();
    test_ignored();
    test_add_timing();
    test_sub_neg();
    test_overflow();
    test_digit_limit();
    test_zero();
    test_held_key();
    test_reset_mid_calc();
    test_chain();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
